// File: rtl/spi_cfg_regfile_pkg.sv
// Shared opcodes, FSM state encoding and address-width helper for the SPI
// configuration register file.
package spi_cfg_pkg;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  // SETF/CLRF carry the flag index in the low nibble; only the high nibble is the opcode.
  localparam logic [7:0] OP_SETF  = 8'h10;
  localparam logic [7:0] OP_CLRF  = 8'h20;
  localparam logic [7:0] OP_CLRE  = 8'h30;

  typedef enum logic [2:0] {
    ST_CMD    = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WDATA  = 3'd2,
    ST_RDATA  = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  function automatic int addr_width(input int addr_bytes);
    return 8 * addr_bytes;
  endfunction

endpackage

// File: rtl/spi_cfg_regfile_if.sv
// SPI pin bundle between the external master and the configuration register file.
interface spi_cfg_regfile_if;
  logic SS;
  logic MOSI;
  logic MISO;

  modport slave  (input SS, input MOSI, output MISO);
  modport master (output SS, output MOSI, input MISO);
endinterface

// File: rtl/spi_cfg_regfile_byte_shifter.sv
// SPI mode-0 byte framer: counts bits, assembles received bytes MSB first and
// shifts the transmit byte out on MISO.
module spi_byte_shifter (
  input  logic       SCLK,
  input  logic       RESET,
  input  logic       ss,
  input  logic       mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       tx_msb
);

  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;

  // byte_done and rx_byte describe the byte that the coming posedge completes.
  assign byte_done = !ss && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_shift, mosi};
  assign tx_msb    = tx_shift[7];

  always_ff @(posedge SCLK or posedge RESET or posedge ss) begin
    if (RESET) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (ss) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else begin
      bit_cnt  <= bit_cnt + 3'd1;
      rx_shift <= rx_byte[6:0];
    end
  end

  // The transmit byte survives deselect; the top gates MISO outside of reads.
  always_ff @(posedge SCLK or posedge RESET) begin
    if (RESET) begin
      tx_shift <= '0;
    end else if (!ss) begin
      tx_shift <= tx_load ? tx_data : {tx_shift[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/spi_cfg_regfile.sv
// SPI slave with byte-wide configuration register file, burst read/write and sticky flags.
// Build option: SPI_ADDR_WRAP_EN makes bursts wrap from DEPTH-1 back to 0.
module spi_cfg_regfile
  import spi_cfg_pkg::*;
#(
  parameter int DEPTH      = 101,
  parameter int ADDR_BYTES = 1,
  parameter int NUM_FLAGS  = 2
) (
  input  logic                 SCLK,
  input  logic                 RESET,
  spi_cfg_regfile_if.slave     spi,
  output logic [DEPTH*8-1:0]   all_data_out,
  output logic [NUM_FLAGS-1:0] ready_flags,
  output logic                 data_valid_out,
  output logic                 instr_done,
  output logic                 addr_err,
  output state_t               fsm_state
);

  localparam int AW  = addr_width(ADDR_BYTES);
  localparam int CW  = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  // Handshake: there is no back-pressure. data_valid_out and instr_done are
  // registered one-cycle pulses raised on the posedge that completes a byte
  // (instr_done only for bytes that executed a command or a write).

  logic       ss;
  logic       byte_done;
  logic [7:0] rx_byte;
  logic       tx_msb;
  logic       tx_load;
  logic [7:0] tx_data;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr, addr_nxt;
  logic [CW-1:0]   abyte_cnt, abyte_cnt_nxt;
  logic            is_read, is_read_nxt;

  logic [7:0]      regs [DEPTH];
  logic            wr_en, set_flag, clr_flag, clr_err, err_set, instr_nxt;
  logic [3:0]      flag_idx;
  logic [AW-1:0]   addr_cat, addr_plus, rd_addr;
  logic [7:0]      rd_byte;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_LIM);
  endfunction

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
`ifdef SPI_ADDR_WRAP_EN
    return ({1'b0, a} >= (DEPTH_LIM - (AW+1)'(1))) ? '0 : a + AW'(1);
`else
    return a + AW'(1);
`endif
  endfunction

  assign ss       = spi.SS;
  assign spi.MISO = (state == ST_RDATA) ? tx_msb : 1'b0;
  assign fsm_state = state;

  spi_byte_shifter u_shifter (
    .SCLK      (SCLK),
    .RESET     (RESET),
    .ss        (ss),
    .mosi      (spi.MOSI),
    .tx_load   (tx_load),
    .tx_data   (tx_data),
    .byte_done (byte_done),
    .rx_byte   (rx_byte),
    .tx_msb    (tx_msb)
  );

  // Address byte shifted in MSB first; the top byte falls off for multi-byte addresses.
  assign addr_cat  = AW'({addr, rx_byte});
  assign addr_plus = addr_inc(addr);
  assign rd_addr   = (state == ST_ADDR) ? addr_cat : addr_plus;

  always_comb begin
    rd_byte = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rd_addr == AW'(k)) rd_byte = regs[k];
    end
  end

  always_ff @(posedge SCLK or posedge RESET or posedge ss) begin
    if (RESET) begin
      state     <= ST_CMD;
      addr      <= '0;
      abyte_cnt <= '0;
      is_read   <= 1'b0;
    end else if (ss) begin
      state     <= ST_CMD;
      addr      <= '0;
      abyte_cnt <= '0;
      is_read   <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      abyte_cnt <= abyte_cnt_nxt;
      is_read   <= is_read_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    abyte_cnt_nxt = abyte_cnt;
    is_read_nxt   = is_read;
    wr_en         = 1'b0;
    set_flag      = 1'b0;
    clr_flag      = 1'b0;
    clr_err       = 1'b0;
    err_set       = 1'b0;
    instr_nxt     = 1'b0;
    tx_load       = 1'b0;
    tx_data       = '0;
    flag_idx      = rx_byte[3:0];

    if (byte_done) begin
      case (state)
        ST_CMD: begin
          if (rx_byte == OP_WRITE || rx_byte == OP_READ) begin
            state_nxt     = ST_ADDR;
            addr_nxt      = '0;
            abyte_cnt_nxt = '0;
            is_read_nxt   = (rx_byte == OP_READ);
          end else begin
            state_nxt = ST_IGNORE;
            if (rx_byte[7:4] == OP_SETF[7:4] && int'(flag_idx) < NUM_FLAGS) begin
              set_flag  = 1'b1;
              instr_nxt = 1'b1;
            end else if (rx_byte[7:4] == OP_CLRF[7:4] && int'(flag_idx) < NUM_FLAGS) begin
              clr_flag  = 1'b1;
              instr_nxt = 1'b1;
            end else if (rx_byte == OP_CLRE) begin
              clr_err   = 1'b1;
              instr_nxt = 1'b1;
            end
          end
        end
        ST_ADDR: begin
          addr_nxt = addr_cat;
          if (int'(abyte_cnt) == ADDR_BYTES - 1) begin
            // Reads prefetch reg[A] here so MISO carries it from the next bit on.
            state_nxt = is_read ? ST_RDATA : ST_WDATA;
            if (is_read) begin
              tx_load = 1'b1;
              tx_data = rd_byte;
              err_set = !in_range(addr_cat);
            end
          end else begin
            abyte_cnt_nxt = abyte_cnt + CW'(1);
          end
        end
        ST_WDATA: begin
          instr_nxt = 1'b1;
          if (in_range(addr)) wr_en   = 1'b1;
          else                err_set = 1'b1;
          addr_nxt = addr_plus;
        end
        ST_RDATA: begin
          addr_nxt = addr_plus;
          tx_load  = 1'b1;
          tx_data  = rd_byte;
          err_set  = !in_range(addr_plus);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SCLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
      ready_flags    <= '0;
      addr_err       <= 1'b0;
      data_valid_out <= 1'b0;
      instr_done     <= 1'b0;
    end else begin
      data_valid_out <= byte_done;
      instr_done     <= instr_nxt;
      for (int k = 0; k < DEPTH; k++) begin
        if (wr_en && addr == AW'(k)) regs[k] <= rx_byte;
      end
      for (int n = 0; n < NUM_FLAGS; n++) begin
        if (set_flag && flag_idx == 4'(n)) ready_flags[n] <= 1'b1;
        if (clr_flag && flag_idx == 4'(n)) ready_flags[n] <= 1'b0;
      end
      if (err_set)      addr_err <= 1'b1;
      else if (clr_err) addr_err <= 1'b0;
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) all_data_out[8*k +: 8] = regs[k];
  end

endmodule
